dec: RTL and testbench
======================

Name: dec

Overview:
- Ring-LWE decryption core over Z_p[x]/(x^N+1).
- Streams in the secret key s and the ciphertext pair (c0, c1), one coefficient per cycle.
- Computes u = c0 − c1·s mod p, where · is negacyclic convolution.
- Decodes each u_k to one message bit and streams the bits out. Sits downstream of key storage and the ciphertext channel.

Parameters:
- p, 17, modulus (prime).
- N, 8, polynomial length (power of 2).
- t, 8, (p−1)/2, the decode centre.
- t_half, 4, t/2, the decode window.
- N_inv, 15, N^−1 mod p. Reserved for NTT-based implementations; unused by the required datapath.
- logP, $clog2(p), coefficient width.
- logN, $clog2(N), index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a decryption; any pulse length.
- sec_key_ready  in  1  key coefficient valid.
- sec_key_s  in  logP  key coefficient, index 0 first.
- cipher_ready  in  1  ciphertext coefficients valid.
- c0_in  in  logP  c0 coefficient, index 0 first.
- c1_in  in  logP  c1 coefficient, same index as c0_in.
- message_ready  out  1  message coefficient valid.
- message  out  logP  decoded bit in LSB, upper bits 0.

Behaviour:
- Reset (synchronous, active-high, priority over everything, also mid-operation):
  - State goes to IDLE, counters clear.
  - message_ready=0, message=0.
  - Stored key, ciphertext and accumulators need not clear.
- All inputs are coefficients in [0, p−1]. Arithmetic is mod p. Intermediate products use at least 2·logP+logN bits, reduced to [0, p−1] before storage.
- State IDLE:
  - start=1 → ARMED.
  - start is ignored in every other state.
- State ARMED:
  - Waits for the first edge with start=0 and sec_key_ready=1; that edge captures s[0].
  - Moves to LOAD_KEY.
- State LOAD_KEY:
  - Captures s[1..N−1] on the next N−1 consecutive edges.
  - sec_key_ready is not re-checked.
  - After s[N−1], spends exactly one TURN cycle, in which inputs are ignored, then → LOAD_CT.
- State LOAD_CT:
  - On each edge with cipher_ready=1, captures c0_in and c1_in at index j, then j++.
  - A cycle with cipher_ready=0 stalls without advancing.
  - After index N−1 → MUL.
- State MUL:
  - Computes r_k = Σ_{i+j=k} c1_i·s_j − Σ_{i+j=k+N} c1_i·s_j mod p.
  - Exactly one multiply-accumulate per cycle, N·N cycles.
  - Iteration order is free; result must be exact.
  - Then → DECODE.
- State DECODE (one cycle):
  - u_k = (c0_k − r_k) mod p.
  - m_k = 1 if |u_k − t| < t_half, else 0.
  - With p=17 this gives m_k=1 for u_k ∈ {5..11}.
- State OUT:
  - message_ready=1 for exactly N consecutive cycles.
  - message = m_0 … m_{N−1} in order.
  - Then message_ready=0, message=0, → IDLE.
- Latency: first message_ready occurs N·N+2 cycles after the edge capturing c[N−1].
- Outputs are registered. message=0 whenever message_ready=0.
- A new start is accepted only once back in IDLE.

Test Plan:
- Reset check: hold reset 10 cycles, then pulse start mid-load and assert reset → message_ready=0, message=0, and the block returns to IDLE. A fresh full transaction afterwards then decodes correctly.
- Nominal transaction:
  - Stimulus: start 2 cycles; s=[12,1,1,12,5,16,16,5]; one turn cycle; c0=[16,11,10,6,10,9,0,3]; c1=[2,9,2,5,6,8,10,5].
  - Required internal values: r=[15,14,16,7,2,10,15,4] and u=[1,14,11,16,8,16,2,16].
  - Required output: message=[0,0,1,0,1,0,0,0], after exactly N·N+2 cycles.
- Zero key: s=all 0, c0=[0,4,5,8,11,12,16,3], c1 arbitrary → message=[0,0,1,1,1,0,0,0]. This checks both window edges (5 and 11 accepted, 4 and 12 rejected).
- Negacyclic wrap: s=[0,0,0,0,0,0,0,1] (x^7), c1=[0,8,0,0,0,0,0,0], c0=0 → r_0=−8≡9, so u_0=8 → m_0=1 and all other m_k=0.
- Stall: drop cipher_ready for 3 cycles mid-ciphertext → result identical to the nominal transaction, shifted by the 3 stall cycles.
- Back-to-back: second start during OUT is ignored; a start after return to IDLE produces a correct second result.

Source files
------------

// File: rtl/dec.sv
// rtl/dec.sv - Ring-LWE decryption core: streamed key/ciphertext load, negacyclic MAC, threshold decode
module dec #(
  parameter int P      = 17,
  parameter int N      = 8,
  parameter int T      = (P - 1) / 2,
  parameter int T_HALF = T / 2,
  parameter int LOGP   = $clog2(P),
  parameter int LOGN   = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            sec_key_ready,
  input  logic [LOGP-1:0] sec_key_s,
  input  logic            cipher_ready,
  input  logic [LOGP-1:0] c0_in,
  input  logic [LOGP-1:0] c1_in,
  output logic            message_ready,
  output logic [LOGP-1:0] message
);

  localparam int PW = 2 * LOGP + LOGN;
  localparam logic [LOGP:0] P_EXT = (LOGP + 1)'(P);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_LOAD_KEY, S_TURN, S_LOAD_CT, S_MUL, S_DECODE, S_OUT
  } state_t;

  state_t            state;
  logic [LOGN-1:0]   idx;
  logic [2*LOGN-1:0] mac_cnt;
  logic [LOGN:0]     out_cnt;
  logic [N-1:0]      m_reg;

  logic [LOGP-1:0] s_mem  [N];
  logic [LOGP-1:0] c0_mem [N];
  logic [LOGP-1:0] c1_mem [N];
  logic [LOGP-1:0] r_acc  [N];

  logic [LOGN-1:0] mac_i, mac_j, mac_k;
  logic            mac_wrap;
  logic [PW-1:0]   mac_prod;
  logic [LOGP:0]   mac_term, mac_sum, mac_diff;
  logic [LOGP-1:0] mac_next;

  // One negacyclic MAC step: c1[i]*s[j] lands in r[(i+j) mod N], negated when i+j wraps past N
  always_comb begin
    mac_i = mac_cnt[2*LOGN-1:LOGN];
    mac_j = mac_cnt[LOGN-1:0];
    {mac_wrap, mac_k} = {1'b0, mac_i} + {1'b0, mac_j};
    mac_prod = PW'(c1_mem[mac_i]) * PW'(s_mem[mac_j]);
    mac_term = (LOGP + 1)'(mac_prod % PW'(P));
    mac_sum  = {1'b0, r_acc[mac_k]} + mac_term;
    mac_diff = {1'b0, r_acc[mac_k]} + P_EXT - mac_term;
    if (mac_wrap)
      mac_next = (mac_diff >= P_EXT) ? LOGP'(mac_diff - P_EXT) : LOGP'(mac_diff);
    else
      mac_next = (mac_sum >= P_EXT) ? LOGP'(mac_sum - P_EXT) : LOGP'(mac_sum);
  end

  logic [LOGP:0] dec_u;
  logic [N-1:0]  dec_bits;

  // Decode: u = c0 - r mod p, bit set when u lies strictly inside (t - t_half, t + t_half)
  always_comb begin
    dec_u    = '0;
    dec_bits = '0;
    for (int k = 0; k < N; k++) begin
      dec_u = {1'b0, c0_mem[k]} + P_EXT - {1'b0, r_acc[k]};
      if (dec_u >= P_EXT) dec_u = dec_u - P_EXT;
      dec_bits[k] = (dec_u > (LOGP + 1)'(T - T_HALF)) && (dec_u < (LOGP + 1)'(T + T_HALF));
    end
  end

  // Control FSM with operand capture, accumulation and registered message output
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      mac_cnt       <= '0;
      out_cnt       <= '0;
      message_ready <= 1'b0;
      message       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_ARMED;
        end
        S_ARMED: begin
          if (!start && sec_key_ready) begin
            s_mem[0] <= sec_key_s;
            idx      <= LOGN'(1);
            state    <= S_LOAD_KEY;
          end
        end
        S_LOAD_KEY: begin
          s_mem[idx] <= sec_key_s;
          idx        <= idx + 1'b1;
          if (idx == LOGN'(N - 1)) state <= S_TURN;
        end
        S_TURN: begin
          idx   <= '0;
          state <= S_LOAD_CT;
        end
        S_LOAD_CT: begin
          if (cipher_ready) begin
            c0_mem[idx] <= c0_in;
            c1_mem[idx] <= c1_in;
            idx         <= idx + 1'b1;
            if (idx == LOGN'(N - 1)) begin
              state   <= S_MUL;
              mac_cnt <= '0;
              for (int q = 0; q < N; q++) r_acc[q] <= '0;
            end
          end
        end
        S_MUL: begin
          r_acc[mac_k] <= mac_next;
          mac_cnt      <= mac_cnt + 1'b1;
          if (mac_cnt == '1) state <= S_DECODE;
        end
        S_DECODE: begin
          m_reg   <= dec_bits;
          out_cnt <= '0;
          state   <= S_OUT;
        end
        S_OUT: begin
          if (out_cnt == (LOGN + 1)'(N)) begin
            message_ready <= 1'b0;
            message       <= '0;
            state         <= S_IDLE;
          end else begin
            message_ready <= 1'b1;
            message       <= {{(LOGP - 1){1'b0}}, m_reg[out_cnt[LOGN-1:0]]};
            out_cnt       <= out_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dec.sv
// tb/tb_dec.sv - scoreboard bench for the Ring-LWE decryption core
module tb_dec;

  localparam int P      = 17;
  localparam int N      = 8;
  localparam int T      = 8;
  localparam int T_HALF = 4;
  localparam int LOGP   = 5;

  typedef int poly_t [N];

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            sec_key_ready;
  logic [LOGP-1:0] sec_key_s;
  logic            cipher_ready;
  logic [LOGP-1:0] c0_in;
  logic [LOGP-1:0] c1_in;
  logic            message_ready;
  logic [LOGP-1:0] message;

  int checks = 0;
  int errors = 0;
  bit sb[$];

  always #5 clk = ~clk;

  dec dut (
    .clk(clk), .reset(reset), .start(start),
    .sec_key_ready(sec_key_ready), .sec_key_s(sec_key_s),
    .cipher_ready(cipher_ready), .c0_in(c0_in), .c1_in(c1_in),
    .message_ready(message_ready), .message(message)
  );

  // Reference model written directly from the ring definition
  function automatic bit [N-1:0] model(input poly_t s, input poly_t c0, input poly_t c1);
    bit [N-1:0] m;
    int r, u;
    for (int k = 0; k < N; k++) begin
      r = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          if (i + j == k) r += c1[i] * s[j];
          else if (i + j == k + N) r -= c1[i] * s[j];
        end
      u = ((c0[k] - r) % P + P) % P;
      m[k] = ((u - T) < T_HALF) && ((T - u) < T_HALF);
    end
    return m;
  endfunction

  task automatic start_pulse(input int len);
    start = 1'b1;
    repeat (len) begin @(posedge clk); #1; end
    start = 1'b0;
  endtask

  task automatic load_key(input poly_t s);
    for (int k = 0; k < N; k++) begin
      sec_key_ready = 1'b1;
      sec_key_s = LOGP'(s[k]);
      @(posedge clk); #1;
    end
    sec_key_ready = 1'b0;
    sec_key_s = LOGP'($urandom_range(P - 1, 0));
    @(posedge clk); #1;
  endtask

  task automatic load_ct(input poly_t c0, input poly_t c1, input int stall_at, input int stall_len);
    for (int j = 0; j < N; j++) begin
      if (j == stall_at) begin
        cipher_ready = 1'b0;
        c0_in = 5'd3;
        c1_in = 5'd7;
        repeat (stall_len) begin @(posedge clk); #1; end
      end
      cipher_ready = 1'b1;
      c0_in = LOGP'(c0[j]);
      c1_in = LOGP'(c1[j]);
      @(posedge clk); #1;
    end
    cipher_ready = 1'b0;
  endtask

  task automatic run_txn(input poly_t s, input poly_t c0, input poly_t c1, input bit [N-1:0] exp,
                         input int stall_at, input int stall_len);
    start_pulse(2);
    load_key(s);
    for (int k = 0; k < N; k++) sb.push_back(exp[k]);
    load_ct(c0, c1, stall_at, stall_len);
  endtask

  task automatic check_output(input string name, input bit poke_start);
    int lat;
    bit seen;
    bit exp;
    seen = 1'b0;
    for (lat = 0; lat < N * N + 50; lat++) begin
      @(negedge clk);
      if (message_ready) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: message_ready never rose (actual 0, required 1)", name);
      sb.delete();
      return;
    end
    checks++;
    if (lat != N * N + 2) begin
      errors++;
      $display("FAIL %s latency: actual %0d required %0d", name, lat, N * N + 2);
    end
    for (int b = 0; b < N; b++) begin
      if (b > 0) @(negedge clk);
      if (poke_start && b == 2) start = 1'b1;
      if (poke_start && b == 3) start = 1'b0;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s bit%0d: scoreboard empty", name, b);
      end else begin
        exp = sb.pop_front();
        if (message_ready !== 1'b1 || message !== LOGP'(exp)) begin
          errors++;
          $display("FAIL %s bit%0d: actual rdy=%b msg=%0d required rdy=1 msg=%0d",
                   name, b, message_ready, message, exp);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (message_ready !== 1'b0 || message !== '0) begin
      errors++;
      $display("FAIL %s end: actual rdy=%b msg=%0d required rdy=0 msg=0", name, message_ready, message);
    end
  endtask

  poly_t s_nom  = '{12, 1, 1, 12, 5, 16, 16, 5};
  poly_t c0_nom = '{16, 11, 10, 6, 10, 9, 0, 3};
  poly_t c1_nom = '{2, 9, 2, 5, 6, 8, 10, 5};
  bit [N-1:0] m_nom = 8'b0001_0100;

  task automatic test_reset();
    bit bad;
    reset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (message_ready !== 1'b0 || message !== '0) begin
        errors++;
        $display("FAIL reset_hold: actual rdy=%b msg=%0d required 0/0", message_ready, message);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    start_pulse(1);
    sec_key_ready = 1'b1;
    sec_key_s = 5'd4;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sec_key_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (message_ready !== 1'b0 || message !== '0) begin
      errors++;
      $display("FAIL reset_midload: actual rdy=%b msg=%0d required 0/0", message_ready, message);
    end
    run_txn(s_nom, c0_nom, c1_nom, m_nom, -1, 0);
    bad = 1'b1;
    for (int i = 0; i < N * N + 20; i++) begin
      @(negedge clk);
      if (message_ready) begin bad = 1'b0; break; end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    checks++;
    if (bad || message_ready !== 1'b0 || message !== '0) begin
      errors++;
      $display("FAIL reset_midout: actual rdy=%b msg=%0d seen=%b required rdy=0 msg=0 seen=1",
               message_ready, message, !bad);
    end
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (message_ready) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_idle: actual output resumed after reset, required none");
    end
    @(posedge clk); #1;
    run_txn(s_nom, c0_nom, c1_nom, m_nom, -1, 0);
    check_output("reset_fresh", 1'b0);
  endtask

  task automatic test_nominal();
    run_txn(s_nom, c0_nom, c1_nom, m_nom, -1, 0);
    check_output("nominal", 1'b0);
  endtask

  task automatic test_zero_key();
    poly_t s0  = '{0, 0, 0, 0, 0, 0, 0, 0};
    poly_t c0  = '{0, 4, 5, 8, 11, 12, 16, 3};
    poly_t c1;
    for (int k = 0; k < N; k++) c1[k] = $urandom_range(P - 1, 0);
    @(posedge clk); #1;
    run_txn(s0, c0, c1, 8'b0001_1100, -1, 0);
    check_output("zero_key", 1'b0);
  endtask

  task automatic test_wrap();
    poly_t s  = '{0, 0, 0, 0, 0, 0, 0, 1};
    poly_t c0 = '{0, 0, 0, 0, 0, 0, 0, 0};
    poly_t c1 = '{0, 8, 0, 0, 0, 0, 0, 0};
    @(posedge clk); #1;
    run_txn(s, c0, c1, 8'b0000_0001, -1, 0);
    check_output("wrap", 1'b0);
  endtask

  task automatic test_stall();
    @(posedge clk); #1;
    run_txn(s_nom, c0_nom, c1_nom, m_nom, 4, 3);
    check_output("stall", 1'b0);
  endtask

  task automatic test_random();
    poly_t s, c0, c1;
    for (int n = 0; n < 3; n++) begin
      for (int k = 0; k < N; k++) begin
        s[k]  = $urandom_range(P - 1, 0);
        c0[k] = $urandom_range(P - 1, 0);
        c1[k] = $urandom_range(P - 1, 0);
      end
      @(posedge clk); #1;
      run_txn(s, c0, c1, model(s, c0, c1), (n == 1) ? 2 : -1, 2);
      check_output("random", 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    poly_t s  = '{3, 0, 7, 1, 16, 2, 9, 5};
    poly_t c0 = '{8, 1, 6, 14, 2, 10, 5, 7};
    poly_t c1 = '{4, 13, 0, 11, 9, 3, 15, 6};
    bit bad;
    @(posedge clk); #1;
    run_txn(s_nom, c0_nom, c1_nom, m_nom, -1, 0);
    check_output("b2b_first", 1'b1);
    @(posedge clk); #1;
    sec_key_ready = 1'b1;
    cipher_ready = 1'b1;
    c0_in = 5'd8;
    c1_in = 5'd1;
    sec_key_s = 5'd1;
    repeat (30) begin @(posedge clk); #1; end
    sec_key_ready = 1'b0;
    cipher_ready = 1'b0;
    bad = 1'b0;
    repeat (N * N + 40) begin
      @(negedge clk);
      if (message_ready) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL b2b_ignored_start: actual output produced, required none");
    end
    @(posedge clk); #1;
    run_txn(s, c0, c1, model(s, c0, c1), -1, 0);
    check_output("b2b_second", 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    sec_key_ready = 1'b0;
    sec_key_s = '0;
    cipher_ready = 1'b0;
    c0_in = '0;
    c1_in = '0;
    test_reset();
    test_nominal();
    test_zero_key();
    test_wrap();
    test_stall();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
